// File: rtl/serial_word_receiver.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits (LSB first), optional even parity, stop bit.
// Good words are held on parallel_out behind a valid/ack handshake; bad frames and overruns pulse flags.
module serial_word_receiver #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             bit_en,
    input  logic             out_ack,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             par_bad_q, par_bad_d;
    logic [WIDTH-1:0] pout_d;
    logic             valid_d, busy_d, frame_err_d, parity_err_d, overrun_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            par_bad_q    <= 1'b0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            par_bad_q    <= par_bad_d;
            parallel_out <= pout_d;
            out_valid    <= valid_d;
            busy         <= busy_d;
            frame_err    <= frame_err_d;
            parity_err   <= parity_err_d;
            overrun      <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        par_bad_d    = par_bad_q;
        pout_d       = parallel_out;
        valid_d      = out_valid;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        overrun_d    = 1'b0;

        // Ack first; a delivery later in this block re-asserts valid with the new word.
        if (out_ack) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!ser_in) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                    end
                end
                DATA: begin
                    sr_d[bit_cnt_q] = ser_in;
                    bit_cnt_d       = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_bad_d = (^sr_q) ^ ser_in;
                    state_d   = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!ser_in) begin
                        frame_err_d  = 1'b1;
                        parity_err_d = par_bad_q;
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                    end else if (!out_valid || out_ack) begin
                        pout_d  = sr_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule
